// File: rtl/echo_stereo_fb_if.sv
// Memory bus between the echo engine and its delay-line RAM.
// The master (echo_stereo_fb) drives the address, write data and write
// enable. The slave (the RAM) returns read data one cycle after the address.
//   mem_q    : read data, slave -> master
//   mem_d    : write data, master -> slave
//   mem_addr : {ptr, ch}; ch 0 = left, ch 1 = right
//   mem_we   : write enable
interface echo_stereo_fb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic signed [DATA_W-1:0] mem_q;
  logic signed [DATA_W-1:0] mem_d;
  logic        [ADDR_W-1:0] mem_addr;
  logic                     mem_we;

  modport master (input mem_q, output mem_d, mem_addr, mem_we);
  modport slave  (output mem_q, input mem_d, mem_addr, mem_we);
endinterface

// File: rtl/echo_stereo_fb.sv
// Stereo feedback echo built on an external single-port delay-line RAM.
// Each accepted stereo pair is handled as read-L, write-L, read-R, write-R:
//   y = sat(x + (delayed >>> fb_shift))
// y is written back into the line, which produces a decaying repeat every
// delay_len samples. In bypass (enable=0) the output is the input, and zeros
// are written so the line is flushed.
// After reset, an INIT pass clears the whole RAM before samples are accepted.
// Ports:
//   clk, ADCLRCK               clock; asynchronous active-high reset
//   sample_stb                 one-cycle strobe qualifying left_in/right_in
//   left_in, right_in          signed input samples
//   delay_len                  echo delay in samples (0 is treated as 1)
//   fb_shift                   feedback gain 2^-fb_shift
//   enable                     echo on / bypass+flush
//   mem                        delay-line RAM bus (master side)
//   left_out, right_out        processed samples, held between updates
//   out_valid                  one-cycle pulse when outputs update
//   busy                       engine not idle
//   overrun                    sticky: a strobe was dropped while busy
module echo_stereo_fb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     ADCLRCK,
  input  logic                     sample_stb,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  input  logic        [ADDR_W-2:0] delay_len,
  input  logic        [2:0]        fb_shift,
  input  logic                     enable,
  echo_stereo_fb_if.master         mem,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [2:0] {INIT, IDLE, RD_L, WR_L, RD_R, WR_R, DONE} state_t;

  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic        [ADDR_W-1:0] init_q, init_d;
  logic        [ADDR_W-2:0] ptr_q, ptr_d;
  logic signed [DATA_W-1:0] xl_q, xl_d, xr_q, xr_d;
  logic        [ADDR_W-2:0] dl_q, dl_d;
  logic        [2:0]        fb_q, fb_d;
  logic                     en_q, en_d;
  logic signed [DATA_W-1:0] yl_q, yl_d;
  logic signed [DATA_W-1:0] lo_q, lo_d, ro_q, ro_d;
  logic                     ov_q, ov_d;
  logic                     orun_q, orun_d;

  logic signed [DATA_W-1:0] x_cur, fb_val, y_sat, y_cur;
  logic        [DATA_W:0]   sum;
  logic        [ADDR_W-1:0] ptr_inc, dl_eff;
  logic        [ADDR_W-2:0] ptr_nxt;
  logic signed [DATA_W-1:0] mem_d_c;
  logic        [ADDR_W-1:0] mem_addr_c;
  logic                     mem_we_c;

  // Feedback datapath: the channel is selected by the write state in progress.
  always_comb begin
    x_cur  = (state_q == WR_R) ? xr_q : xl_q;
    fb_val = $signed(mem.mem_q) >>> fb_q;
    // One guard bit; the sum overflowed when the top two bits differ.
    sum    = {x_cur[DATA_W-1], x_cur} + {fb_val[DATA_W-1], fb_val};
    if (sum[DATA_W] != sum[DATA_W-1]) y_sat = sum[DATA_W] ? S_MIN : S_MAX;
    else                              y_sat = sum[DATA_W-1:0];
    y_cur  = en_q ? y_sat : x_cur;
  end

  // Pointer wrap uses >= rather than ==. If delay_len shrinks below the
  // current pointer, the pointer then returns to 0 on the next advance.
  always_comb begin
    ptr_inc = {1'b0, ptr_q} + ADDR_W'(1);
    dl_eff  = (dl_q == '0) ? ADDR_W'(1) : {1'b0, dl_q};
    ptr_nxt = (ptr_inc >= dl_eff) ? '0 : ptr_inc[ADDR_W-2:0];
  end

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    ptr_d      = ptr_q;
    xl_d       = xl_q;
    xr_d       = xr_q;
    dl_d       = dl_q;
    fb_d       = fb_q;
    en_d       = en_q;
    yl_d       = yl_q;
    lo_d       = lo_q;
    ro_d       = ro_q;
    ov_d       = 1'b0;
    orun_d     = orun_q | (sample_stb && (state_q != IDLE));
    mem_we_c   = 1'b0;
    mem_d_c    = '0;
    mem_addr_c = {ptr_q, 1'b0};
    case (state_q)
      INIT: begin
        mem_we_c   = 1'b1;
        mem_addr_c = init_q;
        init_d     = init_q + ADDR_W'(1);
        if (init_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (sample_stb) begin
          xl_d    = left_in;
          xr_d    = right_in;
          dl_d    = delay_len;
          fb_d    = fb_shift;
          en_d    = enable;
          state_d = RD_L;
        end
      end
      RD_L: state_d = WR_L;
      WR_L: begin
        mem_we_c = 1'b1;
        mem_d_c  = en_q ? y_cur : '0;
        yl_d     = y_cur;
        state_d  = RD_R;
      end
      RD_R: begin
        mem_addr_c = {ptr_q, 1'b1};
        state_d    = WR_R;
      end
      WR_R: begin
        mem_addr_c = {ptr_q, 1'b1};
        mem_we_c   = 1'b1;
        mem_d_c    = en_q ? y_cur : '0;
        // Outputs are registered here so that they are visible during DONE.
        lo_d       = yl_q;
        ro_d       = y_cur;
        ov_d       = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      state_q <= INIT;
      init_q  <= '0;
      ptr_q   <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      dl_q    <= '0;
      fb_q    <= '0;
      en_q    <= 1'b0;
      yl_q    <= '0;
      lo_q    <= '0;
      ro_q    <= '0;
      ov_q    <= 1'b0;
      orun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      ptr_q   <= ptr_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      dl_q    <= dl_d;
      fb_q    <= fb_d;
      en_q    <= en_d;
      yl_q    <= yl_d;
      lo_q    <= lo_d;
      ro_q    <= ro_d;
      ov_q    <= ov_d;
      orun_q  <= orun_d;
    end
  end

  assign mem.mem_d    = mem_d_c;
  assign mem.mem_addr = mem_addr_c;
  assign mem.mem_we   = mem_we_c;
  assign left_out     = lo_q;
  assign right_out    = ro_q;
  assign out_valid    = ov_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = orun_q;

endmodule

// File: tb/tb_echo_stereo_fb.sv
// Bench for echo_stereo_fb (DATA_W=16, ADDR_W=4). A behavioural RAM is
// attached to the bus. A reference model tracks the delay line as an array
// of (pointer, channel) slots and applies the echo rules with integer
// arithmetic.
module tb_echo_stereo_fb;
  localparam int DW = 16;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 ADCLRCK = 1'b0;
  logic                 sample_stb = 1'b0;
  logic signed [DW-1:0] left_in = '0, right_in = '0;
  logic        [AW-2:0] delay_len = '0;
  logic        [2:0]    fb_shift = '0;
  logic                 enable = 1'b0;
  logic signed [DW-1:0] left_out, right_out;
  logic                 out_valid, busy, overrun;

  echo_stereo_fb_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  echo_stereo_fb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .ADCLRCK(ADCLRCK), .sample_stb(sample_stb),
    .left_in(left_in), .right_in(right_in), .delay_len(delay_len),
    .fb_shift(fb_shift), .enable(enable), .mem(mem_if.master),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the address.
  logic signed [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_if.mem_we) ram[mem_if.mem_addr] <= mem_if.mem_d;
    mem_if.mem_q <= ram[mem_if.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mbuf [2**AW];
  int mptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    mptr = 0;
    for (int i = 0; i < 2**AW; i++) mbuf[i] = 0;
  endtask

  // Entered and left at a negedge with all outputs settled.
  task automatic check_init();
    for (int i = 0; i < 2**AW; i++) begin
      chk("init_cycle", {11'h0, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_d, busy},
          {11'h0, 1'b1, 4'(i), 16'h0, 1'b1});
      @(negedge clk);
    end
    chk("init_done_busy", {31'h0, busy}, 32'h0);
  endtask

  // Issue one stereo sample at the current negedge (DUT idle), then check
  // the RAM writes, latency and outputs against the model.
  // stb2_at: cycle (after the accepted strobe) at which to send an illegal second strobe.
  // rst_at : cycle at which to assert reset (aborting the sample).
  task automatic do_sample(input int l, input int r, input int dl, input int sh,
                           input int en, input int stb2_at, input int rst_at);
    int k, dle, p, dL, dR, yL, yR, wL, wR;
    dle = (dl == 0) ? 1 : dl;
    p   = mptr;
    dL  = mbuf[2*p];
    yL  = (en != 0) ? sat16(l + (dL >>> sh)) : l;
    wL  = (en != 0) ? yL : 0;
    mbuf[2*p] = wL;
    dR  = mbuf[2*p+1];
    yR  = (en != 0) ? sat16(r + (dR >>> sh)) : r;
    wR  = (en != 0) ? yR : 0;
    mbuf[2*p+1] = wR;
    mptr = (p + 1 >= dle) ? 0 : p + 1;

    left_in = 16'(l); right_in = 16'(r); delay_len = 3'(dl);
    fb_shift = 3'(sh); enable = en[0]; sample_stb = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) sample_stb = 1'b0;
      if (stb2_at != 0 && k == stb2_at) sample_stb = 1'b1;
      if (stb2_at != 0 && k == stb2_at + 1) sample_stb = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        ADCLRCK = 1'b1;
        #1;
        chk("midrst_lr", {left_out, right_out}, 32'h0);
        chk("midrst_flags", {28'h0, out_valid, overrun, busy, mem_if.mem_we}, 32'h3);
        chk("midrst_bus", {12'h0, mem_if.mem_addr, mem_if.mem_d}, 32'h0);
        model_reset();
        @(negedge clk);
        ADCLRCK = 1'b0;
        check_init();
        return;
      end
      if (k == 2) chk("wr_left", {11'h0, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_d},
                      {11'h0, 1'b1, 4'(2*p), 16'(wL)});
      if (k == 4) chk("wr_right", {11'h0, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_d},
                      {11'h0, 1'b1, 4'(2*p+1), 16'(wR)});
      if (out_valid) break;
    end
    chk("latency", 32'(k), 32'd5);
    chk("left_out", 32'(left_out), 32'(yL));
    chk("right_out", 32'(right_out), 32'(yR));
    @(negedge clk);
    chk("valid_pulse_idle", {30'h0, out_valid, busy}, 32'h0);
    chk("hold_left", 32'(left_out), 32'(yL));
  endtask

  initial begin
    model_reset();
    #2 ADCLRCK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_lr", {left_out, right_out}, 32'h0);
    chk("rst_flags", {28'h0, out_valid, overrun, busy, mem_if.mem_we}, 32'h3);
    chk("rst_bus", {12'h0, mem_if.mem_addr, mem_if.mem_d}, 32'h0);
    ADCLRCK = 1'b0;
    check_init();

    // Impulse with delay 3 and half-gain feedback: 1000,0,0,500,0,0,250,...
    for (int i = 0; i < 10; i++) do_sample((i == 0) ? 1000 : 0, 0, 3, 1, 1, 0, 0);

    // Saturation at both rails, with a bypass flush before each run.
    for (int i = 0; i < 8; i++) do_sample(0, 0, 7, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_sample(30000, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) do_sample(0, 0, 7, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_sample(-30000, -30000, 1, 0, 1, 0, 0);

    // Bypass passes the input through and writes zeros.
    do_sample(1234, -77, 2, 1, 0, 0, 0);

    // Randomized operation.
    for (int i = 0; i < 40; i++)
      do_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0) ? 1 : 0, 0, 0);

    // Delay of 5 until the pointer reaches 4, then shrink to 2.
    for (int n = 0; n < 10 && mptr != 4; n++)
      do_sample(int'($urandom_range(0, 2000)) - 1000, 100, 5, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      do_sample(int'($urandom_range(0, 2000)) - 1000, -100, 2, 1, 1, 0, 0);

    chk("no_overrun_yet", {31'h0, overrun}, 32'h0);
    do_sample(555, 666, 4, 2, 1, 2, 0);
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    do_sample(7, 8, 4, 2, 1, 0, 0);
    chk("overrun_held", {31'h0, overrun}, 32'h1);

    // Reset during WR_L: the sample is aborted and INIT runs again.
    do_sample(4321, 99, 3, 1, 1, 0, 2);
    chk("post_rst_overrun", {31'h0, overrun}, 32'h0);
    for (int i = 0; i < 6; i++) do_sample((i == 0) ? 800 : 0, (i == 1) ? -800 : 0, 2, 2, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
